// File: rtl/sc1_blitter.sv
// Williams SC1 blitter: halts the 6809, copies/fills a W x H block of 4-bit pixels,
// then releases the bus. Sizes are XORed with 4 to reproduce the SC1 erratum.
//   state   | meaning
//   S_IDLE  | waiting for a control write
//   S_HALT  | halt requested, waiting for halt_ack
//   S_READ  | source byte read in progress
//   S_WRITE | processed byte write in progress
//   S_DONE  | bus released, back to idle next edge
module sc1_blitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_sync,
  input  logic        reg_cs,
  input  logic [7:0]  reg_data_in,
  input  logic [2:0]  rs,
  output logic        halt,
  input  logic        halt_ack,
  input  logic        blt_ack,
  output logic [15:0] blt_address_out,
  output logic        read,
  output logic        write,
  input  logic [7:0]  blt_data_in,
  output logic [7:0]  blt_data_out,
  output logic        en_upper,
  output logic        en_lower
);

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_READ, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;

  // Control byte kept without the (ignored) slow bit: {b7..b3, b1, b0}
  logic [6:0]  r_ctrl, r_mode, w_ctrl;
  logic [7:0]  r_mask, r_width, r_height;
  logic [15:0] r_src, r_dst;
  logic        r_go;
  logic [7:0]  r_w, r_col, r_row, r_data;
  logic [3:0]  r_prev;
  logic [15:0] r_src_row, r_src_cur, r_dst_row, r_dst_cur;

  logic        w_ctrl_wr, w_start, w_last;
  logic [7:0]  w_w_x, w_h_x, w_w_eff, w_h_eff, w_d, w_pix;
  logic [15:0] w_src_step, w_src_rstep, w_dst_step, w_dst_rstep;
  logic        w_ss, w_ds, w_fg, w_solid, w_shift, w_no_lo, w_no_hi, w_fg_u, w_fg_l;

  assign w_ctrl_wr = reg_cs && (rs == 3'd0) && (r_state == S_IDLE);
  assign w_start   = e_sync && (r_state == S_IDLE) && (w_ctrl_wr || r_go);
  assign w_ctrl    = w_ctrl_wr ? {reg_data_in[7:3], reg_data_in[1:0]} : r_ctrl;

  assign w_w_x   = r_width ^ 8'h04;
  assign w_h_x   = r_height ^ 8'h04;
  assign w_w_eff = (w_w_x == 8'd0) ? 8'd1 : w_w_x;
  assign w_h_eff = (w_h_x == 8'd0) ? 8'd1 : w_h_x;

  assign {w_no_hi, w_no_lo, w_shift, w_solid, w_fg, w_ds, w_ss} = r_mode;

  assign w_src_step  = w_ss ? 16'h0100 : 16'h0001;
  assign w_dst_step  = w_ds ? 16'h0100 : 16'h0001;
  assign w_src_rstep = w_ss ? 16'h0001 : {8'h00, r_w};
  assign w_dst_rstep = w_ds ? 16'h0001 : {8'h00, r_w};
  assign w_last      = (r_col == 8'd0) && (r_row == 8'd0);

  assign w_d    = w_shift ? {r_prev, r_data[7:4]} : r_data;
  assign w_pix  = w_solid ? r_mask : w_d;
  assign w_fg_u = !w_fg || (w_d[7:4] != 4'h0);
  assign w_fg_l = !w_fg || (w_d[3:0] != 4'h0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl   <= '0;
      r_mask   <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_width  <= '0;
      r_height <= '0;
    end else if (reg_cs) begin
      case (rs)
        3'd0: r_ctrl <= {reg_data_in[7:3], reg_data_in[1:0]};
        3'd1: r_mask <= reg_data_in;
        3'd2: r_src[15:8] <= reg_data_in;
        3'd3: r_src[7:0]  <= reg_data_in;
        3'd4: r_dst[15:8] <= reg_data_in;
        3'd5: r_dst[7:0]  <= reg_data_in;
        3'd6: r_width  <= reg_data_in;
        default: r_height <= reg_data_in;
      endcase
    end
  end

  // A control write on an unqualified edge is remembered until the next qualified one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_go <= 1'b0;
    else if (w_start)   r_go <= 1'b0;
    else if (w_ctrl_wr) r_go <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= '0;
      r_w       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_data    <= '0;
      r_prev    <= '0;
      r_src_row <= '0;
      r_src_cur <= '0;
      r_dst_row <= '0;
      r_dst_cur <= '0;
    end else if (e_sync) begin
      if (w_start) begin
        r_mode    <= w_ctrl;
        r_w       <= w_w_eff;
        r_col     <= w_w_eff - 8'd1;
        r_row     <= w_h_eff - 8'd1;
        r_prev    <= 4'h0;
        r_src_row <= r_src;
        r_src_cur <= r_src;
        r_dst_row <= r_dst;
        r_dst_cur <= r_dst;
      end else if (r_state == S_READ && blt_ack) begin
        r_data <= blt_data_in;
      end else if (r_state == S_WRITE && blt_ack) begin
        if (r_col != 8'd0) begin
          r_col     <= r_col - 8'd1;
          r_src_cur <= r_src_cur + w_src_step;
          r_dst_cur <= r_dst_cur + w_dst_step;
          r_prev    <= r_data[3:0];
        end else if (r_row != 8'd0) begin
          r_row     <= r_row - 8'd1;
          r_col     <= r_w - 8'd1;
          r_src_row <= r_src_row + w_src_rstep;
          r_src_cur <= r_src_row + w_src_rstep;
          r_dst_row <= r_dst_row + w_dst_rstep;
          r_dst_cur <= r_dst_row + w_dst_rstep;
          r_prev    <= 4'h0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (e_sync) begin
      case (r_state)
        S_IDLE:  if (w_start)  w_next = S_HALT;
        S_HALT:  if (halt_ack) w_next = S_READ;
        S_READ:  if (blt_ack)  w_next = S_WRITE;
        S_WRITE: if (blt_ack)  w_next = w_last ? S_DONE : S_READ;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    halt            = 1'b0;
    read            = 1'b0;
    write           = 1'b0;
    blt_address_out = 16'h0000;
    blt_data_out    = 8'h00;
    en_upper        = 1'b0;
    en_lower        = 1'b0;
    case (r_state)
      S_HALT: halt = 1'b1;
      S_READ: begin
        halt            = 1'b1;
        read            = 1'b1;
        blt_address_out = r_src_cur;
      end
      S_WRITE: begin
        halt            = 1'b1;
        write           = 1'b1;
        blt_address_out = r_dst_cur;
        blt_data_out    = {w_fg_u ? w_pix[7:4] : 4'h0, w_fg_l ? w_pix[3:0] : 4'h0};
        en_upper        = !w_no_hi && w_fg_u;
        en_lower        = !w_no_lo && w_fg_l;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sc1_blitter.sv
// Randomised bench for sc1_blitter: each blit is predicted as a list of expected
// read addresses and write beats computed from closed-form block geometry.
module tb_sc1_blitter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_sync = 1'b1;
  logic        reg_cs = 1'b0;
  logic [7:0]  reg_data_in = 8'h00;
  logic [2:0]  rs = 3'd0;
  logic        halt;
  logic        halt_ack = 1'b0;
  logic        blt_ack = 1'b0;
  logic [15:0] blt_address_out;
  logic        read, write;
  logic [7:0]  blt_data_in = 8'h00;
  logic [7:0]  blt_data_out;
  logic        en_upper, en_lower;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] g_data[$];

  sc1_blitter dut (
    .clk(clk), .reset(reset), .e_sync(e_sync), .reg_cs(reg_cs),
    .reg_data_in(reg_data_in), .rs(rs), .halt(halt), .halt_ack(halt_ack),
    .blt_ack(blt_ack), .blt_address_out(blt_address_out), .read(read),
    .write(write), .blt_data_in(blt_data_in), .blt_data_out(blt_data_out),
    .en_upper(en_upper), .en_lower(en_lower)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; rs = a; reg_data_in = d;
    @(negedge clk);
    reg_cs = 1'b0;
  endtask

  task automatic load_regs(input logic [7:0] mask, input logic [15:0] src, input logic [15:0] dst,
                           input logic [7:0] wr, input logic [7:0] hr);
    reg_wr(3'd1, mask);
    reg_wr(3'd2, src[15:8]);
    reg_wr(3'd3, src[7:0]);
    reg_wr(3'd4, dst[15:8]);
    reg_wr(3'd5, dst[7:0]);
    reg_wr(3'd6, wr);
    reg_wr(3'd7, hr);
  endtask

  // cbyte < 0 means random source data; g_data, when filled, overrides both
  task automatic run_blit(input logic [7:0] ctrl, input logic [7:0] mask,
                          input logic [15:0] src, input logic [15:0] dst,
                          input logic [7:0] wr, input logic [7:0] hr,
                          input int cbyte, input bit rnd_hs, input int ack_delay, input bit poke);
    logic [7:0]  dq[$];
    logic [15:0] esrc[$];
    logic [31:0] ewr[$];
    int wi, hi, total, rd_i, wr_i, hcnt, cyc;
    bit done, poked;
    logic [7:0] s, p, d, pix;
    logic [3:0] prev;
    logic [15:0] sa, da;
    bit fu, fl;
    wi = int'(wr ^ 8'h04); if (wi == 0) wi = 1;
    hi = int'(hr ^ 8'h04); if (hi == 0) hi = 1;
    total = wi * hi;
    for (int i = 0; i < total; i++) begin
      if (g_data.size() > 0) dq.push_back(g_data[i % g_data.size()]);
      else if (cbyte >= 0)   dq.push_back(8'(cbyte));
      else                   dq.push_back(8'($urandom));
    end
    g_data.delete();
    for (int r = 0; r < hi; r++) begin
      for (int c = 0; c < wi; c++) begin
        s = dq[r * wi + c];
        if (c == 0) prev = 4'h0;
        else begin p = dq[r * wi + c - 1]; prev = p[3:0]; end
        sa = 16'(int'(src) + r * (ctrl[0] ? 1 : wi) + c * (ctrl[0] ? 256 : 1));
        da = 16'(int'(dst) + r * (ctrl[1] ? 1 : wi) + c * (ctrl[1] ? 256 : 1));
        d   = ctrl[5] ? {prev, s[7:4]} : s;
        pix = ctrl[4] ? mask : d;
        fu  = !ctrl[3] || (d[7:4] != 4'h0);
        fl  = !ctrl[3] || (d[3:0] != 4'h0);
        esrc.push_back(sa);
        ewr.push_back({6'd0, da, fu ? pix[7:4] : 4'h0, fl ? pix[3:0] : 4'h0,
                       !ctrl[7] && fu, !ctrl[6] && fl});
      end
    end

    e_sync = 1'b1; halt_ack = 1'b0; blt_ack = 1'b0;
    load_regs(mask, src, dst, wr, hr);
    reg_wr(3'd0, ctrl);

    rd_i = 0; wr_i = 0; hcnt = 0; cyc = 0; done = 1'b0; poked = 1'b0;
    while (!done && cyc < 3000) begin
      cyc++;
      reg_cs = 1'b0;
      if (halt && !halt_ack) begin
        chk("no_access_before_ack", {30'd0, read, write}, 32'd0);
        if (hcnt >= ack_delay) halt_ack = 1'b1;
        hcnt++;
      end
      e_sync  = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
      blt_ack = rnd_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && !poked && read) begin
        reg_cs = 1'b1; rs = 3'd0; reg_data_in = 8'hFF; poked = 1'b1;
      end
      if (read && blt_ack && e_sync) begin
        if (rd_i < total) begin
          chk("rd_addr", {16'd0, blt_address_out}, {16'd0, esrc[rd_i]});
          blt_data_in = dq[rd_i];
        end else chk("extra_read", rd_i, total);
        rd_i++;
      end
      if (write && blt_ack && e_sync) begin
        if (wr_i < total)
          chk("wr_beat", {6'd0, blt_address_out, blt_data_out, en_upper, en_lower}, ewr[wr_i]);
        else chk("extra_write", wr_i, total);
        wr_i++;
      end
      if (wr_i >= total && !halt) done = 1'b1;
      @(negedge clk);
    end
    chk("blit_finished", {31'd0, done}, 32'd1);
    chk("rd_count", rd_i, total);
    chk("wr_count", wr_i, total);
    reg_cs = 1'b0; e_sync = 1'b1; blt_ack = 1'b0; halt_ack = 1'b0;
    @(negedge clk);
    chk("idle_after", {29'd0, halt, read, write}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    #1;
    chk("reset_outputs", {halt, read, write, en_upper, en_lower, blt_address_out, blt_data_out}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_blit(8'h01, 8'h00, 16'h1122, 16'h3344, 8'h00, 8'h00, 8'h69, 1'b0, 0, 1'b0);
    run_blit(8'h18, 8'hAB, 16'h2000, 16'h4000, 8'h06, 8'h05, 8'h60, 1'b0, 0, 1'b0);
    g_data.push_back(8'h12); g_data.push_back(8'h34);
    run_blit(8'h20, 8'h00, 16'h0100, 16'h0200, 8'h06, 8'h05, -1, 1'b0, 0, 1'b0);
    run_blit(8'h00, 8'h00, 16'h5000, 16'h6000, 8'h07, 8'h06, -1, 1'b1, 10, 1'b0);
    run_blit(8'h40, 8'h00, 16'h0010, 16'h0020, 8'h05, 8'h06, -1, 1'b1, 1, 1'b0);
    run_blit(8'h80, 8'h00, 16'h0030, 16'h0040, 8'h06, 8'h06, -1, 1'b1, 2, 1'b0);
    run_blit(8'h03, 8'h00, 16'hFFFE, 16'hFF00, 8'h07, 8'h07, -1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 14; i++)
      run_blit(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
               8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), -1, 1'b1,
               int'($urandom_range(0, 3)), i == 5);

    // abort mid-blit with reset, then confirm a fresh blit runs
    load_regs(8'h00, 16'h1000, 16'h2000, 8'h00, 8'h00);
    halt_ack = 1'b1; blt_ack = 1'b0;
    reg_wr(3'd0, 8'h00);
    repeat (4) @(negedge clk);
    chk("pre_abort_read", {31'd0, read}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", {29'd0, halt, read, write}, 32'd0);
    @(negedge clk);
    reset = 1'b1; halt_ack = 1'b0;
    @(negedge clk);
    run_blit(8'h01, 8'h00, 16'h1122, 16'h3344, 8'h01, 8'h06, -1, 1'b1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sc1_blitter.md
Name: sc1_blitter

Overview:
- Williams SC1 "special chip" blitter: copies/fills rectangular blocks of 4-bit-pixel (two pixels per byte) memory.
- Sits on the 6809 bus as an 8-register write-only peripheral.
- A control-register write starts a block transfer: it halts the CPU, runs read/write cycles on the blitter bus, then releases the CPU.

Parameters:
- None. Size rule is fixed: width/height are XORed with 4, per the SC1 erratum.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
e_sync  in  1  bus-phase qualifier; blitter state advances only on clk edges where e_sync=1
reg_cs  in  1  register write strobe, one clk per write
reg_data_in  in  8  register write data
rs  in  3  register select
halt  out  1  CPU halt request
halt_ack  in  1  CPU has halted; bus granted
blt_ack  in  1  current read/write access completed
blt_address_out  out  16  blitter bus address
read  out  1  read request
write  out  1  write request
blt_data_in  in  8  read data
blt_data_out  out  8  write data
en_upper  out  1  write enable, bits 7:4
en_lower  out  1  write enable, bits 3:0

Behaviour:
- Reset (reset=0, async) clears:
  - all registers, halt, read, write, en_upper and en_lower to 0;
  - blt_address_out and blt_data_out to 0x0000 / 0x00;
  - the FSM to IDLE.
- Register writes happen on a clk edge with reg_cs=1, in any state:
  - rs0 = control; in IDLE this also starts a blit;
  - rs1 = mask/solid colour;
  - rs2/rs3 = source address high/low;
  - rs4/rs5 = destination address high/low;
  - rs6 = width; rs7 = height.
- Effective size: W = width XOR 4, H = height XOR 4. A result of 0 is treated as 1.
- Control bits:
  - b0 = source stride 256;
  - b1 = destination stride 256;
  - b2 = slow (ignored);
  - b3 = foreground only;
  - b4 = solid;
  - b5 = shift right one nibble;
  - b6 = suppress lower-nibble writes;
  - b7 = suppress upper-nibble writes.
- FSM: IDLE -> HALT -> READ -> WRITE -> (READ | DONE) -> IDLE.
  - IDLE: a control write latches control and copies src/dst into row/column counters; next state HALT.
  - HALT: halt=1. Wait for halt_ack=1 (sampled on a qualified edge), then go to READ.
  - READ: read=1, blt_address_out = current source address. On an edge with blt_ack=1, latch blt_data_in and go to WRITE.
  - WRITE: write=1, blt_address_out = current destination address, blt_data_out = processed data. On an edge with blt_ack=1, advance counters; after the W*H-th byte go to DONE, otherwise READ.
  - DONE: drop halt, read and write, then go to IDLE.
  - halt stays 1 continuously from HALT through DONE entry.
- Address stepping (16-bit wrap-around):
  - within a row, an address advances by 256 if its stride bit is set, else by 1;
  - at end of row, the row-start address advances by 1 if stride is set, else by W;
  - source and destination step independently.
- Data path, per byte:
  - shift: d = {previous_src[3:0], src[7:4]}; previous_src is cleared at the start of each row;
  - solid: output nibbles come from the mask register, else from d;
  - foreground only: a nibble is enabled only if the corresponding d nibble is nonzero;
  - en_upper = !b7 && upper-nibble enable; en_lower = !b6 && lower-nibble enable;
  - the enables are valid only while write=1 and are 0 otherwise.
- Control writes during a blit are stored but do not restart it.
- Reset mid-blit aborts it immediately and drops halt.
- Edges with e_sync=0 freeze all FSM and counter state; register writes are still accepted.

Test Plan:
- Reset: assert reset=0 with a blit running -> halt, read and write go to 0 at once; after release a new control write starts cleanly.
- Basic stride blit (e_sync=1):
  - stimulus: write src=0x1122, dst=0x3344, w=0, h=0, then control=0x01; at halt=1 raise halt_ack, hold blt_ack=1 and blt_data_in=0x69;
  - required: 16 read/write pairs (4x4); source addresses 0x1122, 0x1222, 0x1322, 0x1422, then 0x1123, ...; destination addresses 0x3344, 0x3345, 0x3346, 0x3347, 0x3348, ...; blt_data_out=0x69 with en_upper=en_lower=1; halt falls afterwards.
- Solid and foreground: control=0x18, mask=0xAB, source data 0x60 -> written 0xA0 with en_upper=1, en_lower=0.
- Shift: control=0x20, row data 0x12 then 0x34 -> writes 0x01, then 0x23.
- Handshake: hold halt_ack=0 for 10 cycles -> no read/write asserted; toggle blt_ack -> each access is held until acknowledged; e_sync=0 stalls progress.
- Nibble suppression: control=0x40 -> en_lower=0 on every write; control=0x80 -> en_upper=0.
